// File: rtl/module_booth_seq.sv
//==============================================================================
// Module      : module_booth_seq
// Description : Sequential radix-2 Booth multiplier, N-bit operands, 2N-bit
//               product, run-time signed/unsigned mode, start/busy/done.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module module_booth_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW    = $clog2(N + 2);
  localparam logic [CW-1:0] ITERS = CW'(N + 1);

  state_t            state_q;
  logic [2*N+1:0]    acc_q;
  logic              qm1_q;
  logic [N:0]        mcand_q;
  logic [CW-1:0]     cnt_q;
  logic [2*N-1:0]    p_q;
  logic              busy_q;
  logic              done_q;

  logic [N:0]        ext_a;
  logic [N:0]        ext_b;
  logic [N:0]        upper;
  logic [N:0]        upper_d;
  logic [2*N+1:0]    acc_d;

  // One extra bit keeps the negation of the most-negative multiplicand exact.
  assign ext_a = {signed_mode & a[N-1], a};
  assign ext_b = {signed_mode & b[N-1], b};
  assign upper = acc_q[2*N+1:N+1];

  always_comb begin
    upper_d = upper;
    case ({acc_q[0], qm1_q})
      2'b01:   upper_d = upper + mcand_q;
      2'b10:   upper_d = upper - mcand_q;
      default: upper_d = upper;
    endcase
    acc_d = {upper_d[N], upper_d, acc_q[N:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init) begin
            mcand_q <= ext_a;
            acc_q   <= {{(N+1){1'b0}}, ext_b};
            qm1_q   <= 1'b0;
            cnt_q   <= ITERS;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          qm1_q <= acc_q[0];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          p_q     <= acc_q[2*N-1:0];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_module_booth_seq.sv
//==============================================================================
// Module      : tb_module_booth_seq
// Description : Scoreboard bench for module_booth_seq at N=4 and N=8.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_module_booth_seq;

  logic clk;
  logic rst4, rst8;
  logic init4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic init8, sm8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int n_chk;
  int n_pass;
  logic [15:0] exp4_q[$];
  logic [15:0] exp8_q[$];
  logic prev_done4, prev_done8;

  module_booth_seq #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst4), .init(init4), .signed_mode(sm4),
    .a(a4), .b(b4), .p(p4), .busy(busy4), .done(done4)
  );

  module_booth_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst8), .init(init8), .signed_mode(sm8),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_mul(input int n, input logic [7:0] av,
                                          input logic [7:0] bv, input logic sm);
    longint mask, x, y;
    mask = (longint'(1) << n) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (sm && av[n-1]) x = x - (longint'(1) << n);
    if (sm && bv[n-1]) y = y - (longint'(1) << n);
    return 16'((x * y) & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // Result monitors: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (rst4 && done4) begin
      if (exp4_q.size() == 0) chk("p4_unexpected_done", 16'd1, 16'd0);
      else chk("p4", {8'h00, p4}, exp4_q.pop_front());
      chk("done4_back_to_back", {15'd0, prev_done4}, 16'd0);
    end
    prev_done4 = done4;
  end

  always @(negedge clk) begin
    if (rst8 && done8) begin
      if (exp8_q.size() == 0) chk("p8_unexpected_done", 16'd1, 16'd0);
      else chk("p8", p8, exp8_q.pop_front());
      chk("done8_back_to_back", {15'd0, prev_done8}, 16'd0);
    end
    prev_done8 = done8;
  end

  task automatic start_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input logic [15:0] exp, input bit push);
    @(negedge clk);
    if (w == 4) begin
      a4 = av[3:0]; b4 = bv[3:0]; sm4 = sm; init4 = 1'b1;
      if (push) exp4_q.push_back(exp);
    end else begin
      a8 = av; b8 = bv; sm8 = sm; init8 = 1'b1;
      if (push) exp8_q.push_back(exp);
    end
    @(negedge clk);
    init4 = 1'b0;
    init8 = 1'b0;
  endtask

  task automatic wait_done(input int w, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    forever begin
      if ((w == 4) ? busy4 : busy8) nbusy++;
      if ((w == 4) ? done4 : done8) break;
      if (lat >= 40) begin
        chk("done_timeout", 16'd1, 16'd0);
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input logic [15:0] exp);
    int lat, nb;
    start_op(w, av, bv, sm, exp, 1'b1);
    wait_done(w, lat, nb);
  endtask

  initial begin
    int lat, nb, ndone;
    int d[3];
    logic [7:0] ra, rb;
    logic rs;
    n_chk = 0; n_pass = 0;
    prev_done4 = 1'b0; prev_done8 = 1'b0;
    init4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    init8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    rst4 = 1'b1; rst8 = 1'b1;
    #3;
    rst4 = 1'b0; rst8 = 1'b0;
    #1;
    chk("reset_p4", {8'h00, p4}, 16'h0000);
    chk("reset_busy4", {15'd0, busy4}, 16'd0);
    chk("reset_done4", {15'd0, done4}, 16'd0);
    chk("reset_p8", p8, 16'h0000);
    repeat (2) @(negedge clk);
    rst4 = 1'b1; rst8 = 1'b1;

    // 15*15 unsigned with latency and busy-length checks
    start_op(4, 8'd15, 8'd15, 1'b0, 16'h00E1, 1'b1);
    wait_done(4, lat, nb);
    chk("latency_n4", 16'(lat), 16'd6);
    chk("busy_cycles_n4", 16'(nb), 16'd5);
    chk("p4_direct", {8'h00, p4}, 16'h00E1);
    @(negedge clk);
    chk("done4_one_cycle", {15'd0, done4}, 16'd0);

    run_op(4, 8'h08, 8'h08, 1'b1, 16'h0040);
    run_op(4, 8'h07, 8'h0D, 1'b1, 16'h00EB);
    run_op(4, 8'h00, 8'h09, 1'b0, 16'h0000);
    run_op(4, 8'h0D, 8'h03, 1'b0, 16'h0027);
    run_op(4, 8'h0D, 8'h03, 1'b1, 16'h00F7);

    // init retriggered while busy and in DONE, with new operands: ignored
    start_op(4, 8'd5, 8'd6, 1'b0, 16'h001E, 1'b1);
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done4) ndone++;
      init4 = (i == 1 || i == 4 || i == 5);
      if (init4) begin a4 = 4'd1; b4 = 4'd1; sm4 = 1'b1; end
    end
    chk("retrigger_done_count", 16'(ndone), 16'd1);

    // init held high: a new operation on each IDLE visit
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; init4 = 1'b1;
    repeat (3) exp4_q.push_back(16'h000F);
    ndone = 0;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      if (done4) begin
        if (ndone < 3) d[ndone] = i;
        ndone++;
      end
      if (i == 14) init4 = 1'b0;
    end
    chk("hold_done_count", 16'(ndone), 16'd3);
    if (ndone == 3) begin
      chk("hold_period_1", 16'(d[1] - d[0]), 16'd7);
      chk("hold_period_2", 16'(d[2] - d[1]), 16'd7);
    end

    // reset in the middle of CALC abandons the operation
    start_op(4, 8'd9, 8'd9, 1'b0, 16'h0051, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst4 = 1'b0;
    #1;
    chk("midreset_p4", {8'h00, p4}, 16'h0000);
    chk("midreset_busy4", {15'd0, busy4}, 16'd0);
    chk("midreset_done4", {15'd0, done4}, 16'd0);
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("midreset_no_done", 16'(ndone), 16'd0);
    run_op(4, 8'd2, 8'd3, 1'b0, 16'h0006);

    // N=8 most-negative squared
    start_op(8, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    wait_done(8, lat, nb);
    chk("latency_n8", 16'(lat), 16'd10);
    chk("busy_cycles_n8", 16'(nb), 16'd9);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run_op(8, ra, rb, rs, ref_mul(8, ra, rb, rs));
    end
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rs = 1'($urandom);
      run_op(4, ra, rb, rs, ref_mul(4, ra, rb, rs));
    end

    repeat (3) @(negedge clk);
    chk("q4_drained", 16'(exp4_q.size()), 16'd0);
    chk("q8_drained", 16'(exp8_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/module_booth_seq.md
Name: module_booth_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next-generation arithmetic core behind the keypad/display top level.
- Generalises the fixed 4-bit multiplier to N-bit operands.
- Adds a run-time signed/unsigned mode and a start/busy/done handshake.
- Sits between the keypad operand registers (a, b, rdy→init) and the display path (p, done→load_m).

Parameters:
N, 4, operand width in bits; legal range N >= 2; product width is 2N.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
init  input  1  start request; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled together with init.
a  input  N  multiplicand; sampled with init.
b  input  N  multiplier; sampled with init.
p  output  2N  product; holds the last result until the next result is written.
busy  output  1  high from the cycle after init is accepted until done.
done  output  1  one-cycle pulse when p has been updated.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE; p=0, busy=0, done=0; all internal registers cleared.
  - An operation in progress is abandoned; no done pulse is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - init=1 at a rising edge captures the operands and moves to CALC.
  - Operands are extended to N+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - The accumulator is 2N+2 bits: {N+1 zeros, extended b}. The Booth bit q(-1)=0. Iteration count=N+1.
  - busy=1 from this edge.
- CALC, one iteration per cycle:
  - Examine {acc[0], q(-1)}: 01 → add extended a to the upper N+1 bits; 10 → subtract it; 00/11 → no operation.
  - Then arithmetic right shift of {acc, q(-1)} by one bit; decrement the count.
  - Add/subtract wraps modulo 2^(N+1).
  - After the (N+1)th iteration, go to DONE.
- DONE (one cycle): p ← acc[2N-1:0]; done=1; busy=0; next state IDLE.
- Latency: init sampled at edge 0; iterations at edges 1..N+1; p updated and done=1 after edge N+2. Total N+2 cycles, independent of operand values.
- Throughput: the earliest next init is accepted in IDLE, one cycle after DONE, so the minimum period is N+3 cycles.
- init while busy (CALC or DONE): ignored, not queued. Changes to a, b or signed_mode during CALC have no effect.
- init held high continuously: a new operation starts on each IDLE visit.
- p is stable except on the DONE edge and at reset. done is never high on two consecutive cycles.
- Result correctness:
  - Unsigned: p = a*b exactly.
  - Signed: p = two's-complement a*b in 2N bits. This includes (−2^(N−1))² = 2^(2N−2), which fits.
- Width rules:
  - No overflow flag is needed; every result fits in 2N bits in both modes.
  - Internal width of N+1 bits avoids overflow on subtracting the most-negative multiplicand.

Test Plan:
- N=4, unsigned, a=15, b=15, pulse init → after 6 cycles done=1 for one cycle, p=8'hE1 (225); busy high for exactly 5 cycles before done.
- N=4, signed, a=4'b1000 (−8), b=4'b1000 (−8) → p=8'h40 (64). Then signed a=7, b=4'b1101 (−3) → p=8'hEB (−21).
- N=4, unsigned, a=0, b=9 → p=8'h00. Then unsigned a=4'b1101 (13), b=3 → p=8'h27 (39), versus signed mode with the same bits → p=8'hF7 (−9).
- Handshake: init pulsed again on cycles 2 and 5 of a busy operation, with a/b changed → ignored; only one done pulse; p reflects the original operands. init held high permanently → done pulses every 7 cycles (N=4).
- Reset mid-operation: drop rst to 0 during CALC cycle 3 → p=0, busy=0, done=0 immediately; no later done pulse. After release, a fresh init with a=2, b=3 → p=8'h06.
- N=8, signed, a=8'h80, b=8'h80 → p=16'h4000 after 10 cycles. Random constrained sweep: both modes, 1000 pairs, compared against a reference model.
